// File: rtl/decode_operand_stage_pkg.sv
// decode_operand_stage_pkg
// Shared constants and helpers for the decode/operand stage:
//   - opcode constants for the R-type group and the logical-immediate ops
//   - register address width and the hard-wired zero register
//   - is_zero_ext_op(): true for opcodes whose immediate is zero-extended
package decode_operand_stage_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    // Logical immediates treat the 16-bit field as unsigned.
    function automatic logic is_zero_ext_op(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/decode_operand_stage_register_file.sv
// decode_operand_stage_register_file
// NREGS x DATA_W register file with two combinational read ports and one
// synchronous write port. Register 0 always reads zero and ignores writes.
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low clear
//   raddr_a/rdata_a      read port A
//   raddr_b/rdata_b      read port B
//   we, waddr, wdata     write port (ignored when waddr == 0)
module decode_operand_stage_register_file
    import decode_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  reg_addr_t         raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  reg_addr_t         raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  reg_addr_t         waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != REG_ZERO)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata_a = (raddr_a == REG_ZERO) ? '0 : regs_q[raddr_a];
        rdata_b = (raddr_b == REG_ZERO) ? '0 : regs_q[raddr_b];
    end

endmodule

// File: rtl/decode_operand_stage.sv
// decode_operand_stage
// Reads source operands for a decoded instruction, extends its immediate and
// latches the result into the decode/execute pipeline register. Also owns the
// register-file writeback port.
// Ports:
//   clock, reset                  rising-edge clock, async active-low reset
//   in_valid/in_ready             upstream handshake (decoded instruction)
//   in_pc, opcode, rs, rt, rd,    decoded fields
//   shamt, funct, immediate,
//   isRtype, isItype
//   flush                         drop held and incoming instruction
//   wb_en, wb_addr, wb_data       register-file write port
//   out_valid/out_ready           downstream handshake
//   ex_*                          registered execute-side payload
// Build option: DECODE_OPERAND_BYPASS_EN -- when defined, a writeback on the
// capture edge to rs/rt is forwarded into the captured operand.
module decode_operand_stage
    import decode_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 4,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       immediate,
    input  logic              isRtype,
    input  logic              isItype,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   ex_pc,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic [4:0]        ex_shamt,
    output logic              ex_isRtype,
    output logic              ex_isItype,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_dest
);

    logic [DATA_W-1:0] rf_rs_data, rf_rt_data;
    logic [DATA_W-1:0] rs_val, rt_val, imm_ext;
    reg_addr_t         dest_sel;
    logic              capture, wb_hit;

    logic              out_valid_q, out_valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [5:0]        funct_q, funct_d;
    logic [4:0]        shamt_q, shamt_d;
    logic              isr_q, isr_d;
    logic              isi_q, isi_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    reg_addr_t         dest_q, dest_d;
    // Source addresses of the held instruction, for hold-refresh matching.
    reg_addr_t         rs_addr_q, rs_addr_d;
    reg_addr_t         rt_addr_q, rt_addr_d;

    decode_operand_stage_register_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_register_file (
        .clock   (clock),
        .reset   (reset),
        .raddr_a (rs),
        .rdata_a (rf_rs_data),
        .raddr_b (rt),
        .rdata_b (rf_rt_data),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign wb_hit   = wb_en && (wb_addr != REG_ZERO);

    always_comb begin
        rs_val = rf_rs_data;
        rt_val = rf_rt_data;
`ifdef DECODE_OPERAND_BYPASS_EN
        if (wb_hit && (wb_addr == rs)) rs_val = wb_data;
        if (wb_hit && (wb_addr == rt)) rt_val = wb_data;
`endif
    end

    always_comb begin
        if (isRtype) begin
            imm_ext = '0;
        end else if (is_zero_ext_op(opcode)) begin
            imm_ext = {{(DATA_W-16){1'b0}}, immediate};
        end else begin
            imm_ext = {{(DATA_W-16){immediate[15]}}, immediate};
        end
        dest_sel = isRtype ? rd : (isItype ? rt : REG_ZERO);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        pc_d        = pc_q;
        opcode_d    = opcode_q;
        funct_d     = funct_q;
        shamt_d     = shamt_q;
        isr_d       = isr_q;
        isi_d       = isi_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        dest_d      = dest_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            pc_d        = in_pc;
            opcode_d    = opcode;
            funct_d     = funct;
            shamt_d     = shamt;
            isr_d       = isRtype;
            isi_d       = isItype;
            rs_data_d   = rs_val;
            rt_data_d   = rt_val;
            imm_d       = imm_ext;
            dest_d      = dest_sel;
            rs_addr_d   = rs;
            rt_addr_d   = rt;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q && wb_hit) begin
            // Stalled: keep the held operands coherent with the register file.
            if (wb_addr == rs_addr_q) rs_data_d = wb_data;
            if (wb_addr == rt_addr_q) rt_data_d = wb_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            opcode_q    <= '0;
            funct_q     <= '0;
            shamt_q     <= '0;
            isr_q       <= 1'b0;
            isi_q       <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            dest_q      <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            opcode_q    <= opcode_d;
            funct_q     <= funct_d;
            shamt_q     <= shamt_d;
            isr_q       <= isr_d;
            isi_q       <= isi_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            dest_q      <= dest_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign ex_pc      = pc_q;
    assign ex_opcode  = opcode_q;
    assign ex_funct   = funct_q;
    assign ex_shamt   = shamt_q;
    assign ex_isRtype = isr_q;
    assign ex_isItype = isi_q;
    assign ex_rs_data = rs_data_q;
    assign ex_rt_data = rt_data_q;
    assign ex_imm     = imm_q;
    assign ex_dest    = dest_q;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Testbench for decode_operand_stage: a reference model predicts each
// accepted instruction's payload into a queue; a monitor on the falling edge
// compares the presented payload against the queue head.
module tb_decode_operand_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid, in_ready;
    logic [3:0]  in_pc;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] immediate;
    logic        isRtype, isItype, flush, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [3:0]  ex_pc;
    logic [5:0]  ex_opcode, ex_funct;
    logic [4:0]  ex_shamt, ex_dest;
    logic        ex_isRtype, ex_isItype;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;

    always #5 clock = ~clock;

    decode_operand_stage #(
        .DATA_W (32),
        .PC_W   (4),
        .NREGS  (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .immediate  (immediate),
        .isRtype    (isRtype),
        .isItype    (isItype),
        .flush      (flush),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ex_pc      (ex_pc),
        .ex_opcode  (ex_opcode),
        .ex_funct   (ex_funct),
        .ex_shamt   (ex_shamt),
        .ex_isRtype (ex_isRtype),
        .ex_isItype (ex_isItype),
        .ex_rs_data (ex_rs_data),
        .ex_rt_data (ex_rt_data),
        .ex_imm     (ex_imm),
        .ex_dest    (ex_dest)
    );

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic [4:0]  rs;
        logic [4:0]  rt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_regs [32];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Expected payload of the instruction currently on the inputs.
    function automatic exp_t make_exp();
        exp_t e;
        e.rs   = rs;
        e.rt   = rt;
        e.a    = (rs == 0) ? 32'd0 : ref_regs[rs];
        e.b    = (rt == 0) ? 32'd0 : ref_regs[rt];
`ifdef DECODE_OPERAND_BYPASS_EN
        if (wb_en && wb_addr != 0 && wb_addr == rs) e.a = wb_data;
        if (wb_en && wb_addr != 0 && wb_addr == rt) e.b = wb_data;
`endif
        if (isRtype) e.imm = 32'd0;
        else if (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E) e.imm = {16'd0, immediate};
        else e.imm = 32'($signed(immediate));
        if (isRtype) e.dest = rd;
        else if (isItype) e.dest = rt;
        else e.dest = 5'd0;
        e.ctrl = {9'd0, in_pc, opcode, funct, shamt, isRtype, isItype};
        return e;
    endfunction

    // Predicts the effect of the coming rising edge; runs after the monitor
    // has retired any accepted item, so a non-empty queue means "stalled".
    task automatic model_edge();
        exp_t held;
        if (flush) begin
            if (exp_q.size() != 0) exp_q.delete();
        end else if (in_valid && exp_q.size() == 0) begin
            exp_q.push_back(make_exp());
        end else if (exp_q.size() != 0 && wb_en && wb_addr != 0) begin
            held = exp_q[0];
            if (wb_addr == held.rs) held.a = wb_data;
            if (wb_addr == held.rt) held.b = wb_data;
            exp_q[0] = held;
        end
        if (wb_en && wb_addr != 0) ref_regs[wb_addr] = wb_data;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            check("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() == 0) || out_ready});
            if (out_valid && exp_q.size() != 0) begin
                check("ex_ctrl", {9'd0, ex_pc, ex_opcode, ex_funct, ex_shamt, ex_isRtype,
                                  ex_isItype}, exp_q[0].ctrl);
                check("ex_rs_data", ex_rs_data, exp_q[0].a);
                check("ex_rt_data", ex_rt_data, exp_q[0].b);
                check("ex_imm", ex_imm, exp_q[0].imm);
                check("ex_dest", {27'd0, ex_dest}, {27'd0, exp_q[0].dest});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(negedge clock);
        #1;
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic nop();
        in_valid = 1'b0;
        flush    = 1'b0;
        wb_en    = 1'b0;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [15:0] imm, input logic r,
                         input logic i);
        in_valid  = 1'b1;
        in_pc     = 4'($urandom);
        opcode    = op;
        rs        = s;
        rt        = t;
        rd        = d;
        immediate = imm;
        isRtype   = r;
        isItype   = i;
        funct     = 6'($urandom);
        shamt     = 5'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        nop();
        issue(6'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0);
        in_valid  = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset ex_rs_data", ex_rs_data, 32'd0);
        check("reset ex_imm", ex_imm, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1 mon_en = 1'b1;
        @(posedge clock);
        #1;

        // Write then read, R-type.
        wb(1'b1, 5'd5, 32'h0000_1234); cyc();
        wb(1'b1, 5'd6, 32'hFFFF_0001); cyc();
        wb(1'b0, 5'd0, 32'd0);
        issue(6'h00, 5'd5, 5'd6, 5'd7, 16'h1234, 1'b1, 1'b0); cyc();
        nop(); cyc();

        // Immediate extension and r0.
        issue(6'h08, 5'd2, 5'd3, 5'd4, 16'h8000, 1'b0, 1'b1); cyc();
        issue(6'h0D, 5'd1, 5'd8, 5'd2, 16'h8000, 1'b0, 1'b1); cyc();
        nop(); wb(1'b1, 5'd0, 32'h0000_DEAD); cyc();
        wb(1'b0, 5'd0, 32'd0);
        issue(6'h08, 5'd0, 5'd5, 5'd0, 16'h0010, 1'b0, 1'b1); cyc();
        nop(); cyc();

        // Backpressure with hold-refresh of the held rs.
        issue(6'h00, 5'd5, 5'd6, 5'd7, 16'h0, 1'b1, 1'b0); cyc();
        out_ready = 1'b0;
        issue(6'h08, 5'd1, 5'd2, 5'd3, 16'h0042, 1'b0, 1'b1);
        cyc();
        wb(1'b1, 5'd5, 32'h0000_ABCD); cyc();
        wb(1'b0, 5'd0, 32'd0); cyc();
        out_ready = 1'b1; nop(); cyc(); cyc();

        // Back-to-back captures.
        for (int i = 0; i < 6; i++) begin
            issue(6'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
                  16'($urandom), 1'b0, 1'b1);
            cyc();
        end
        nop(); cyc();

        // Flush of incoming, then flush of a held instruction.
        issue(6'h08, 5'd5, 5'd6, 5'd1, 16'h0001, 1'b0, 1'b1); flush = 1'b1; cyc();
        nop(); cyc();
        issue(6'h08, 5'd5, 5'd6, 5'd1, 16'h0001, 1'b0, 1'b1); cyc();
        out_ready = 1'b0; nop(); flush = 1'b1; cyc();
        flush = 1'b0; out_ready = 1'b1; cyc();

        // Same-edge capture and writeback.
        wb(1'b1, 5'd9, 32'h0000_0011); cyc();
        wb(1'b1, 5'd9, 32'h0000_0055);
        issue(6'h00, 5'd9, 5'd0, 5'd3, 16'h0, 1'b1, 1'b0); cyc();
        nop(); cyc();

        // Reset while an instruction is held.
        issue(6'h00, 5'd5, 5'd6, 5'd7, 16'h0, 1'b1, 1'b0); out_ready = 1'b0; cyc();
        nop(); mon_en = 1'b0; reset = 1'b0;
        #1;
        check("midreset out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset ex_rs_data", ex_rs_data, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        @(negedge clock);
        reset = 1'b1;
        out_ready = 1'b1;
        issue(6'h00, 5'd5, 5'd5, 5'd1, 16'h0, 1'b1, 1'b0);
        #1 mon_en = 1'b1;
        model_edge();
        @(posedge clock);
        #1;
        nop(); cyc();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            issue(6'($urandom_range(0, 15)), 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
                  5'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb(1'($urandom), 5'($urandom_range(0, 11)), $urandom);
            cyc();
        end

        nop(); out_ready = 1'b1;
        repeat (3) cyc();
        check("drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
- Sits directly downstream of the instruction decoder in the fetch/decode path.
- Consumes the decoded fields (opcode, rs, rt, rd, shamt, funct, immediate, isRtype, isItype) plus the fetch PC.
- Reads source operands from an internal 32x32 register file and extends the immediate.
- Latches everything into a decode/execute pipeline register with valid/ready handshake and flush; also owns the register-file write (writeback) port.

Parameters:
- DATA_W, 32, register and operand width
- PC_W, 4, width of the PC carried with the instruction
- NREGS, 32, register count (address width fixed at 5)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept this cycle
- in_pc  in  PC_W  PC of the decoded instruction
- opcode  in  6  decoded opcode
- rs  in  5  source register 1
- rt  in  5  source register 2 / I-type destination
- rd  in  5  R-type destination
- shamt  in  5  shift amount
- funct  in  6  R-type function
- immediate  in  16  I-type immediate
- isRtype  in  1  R-type flag
- isItype  in  1  I-type flag
- flush  in  1  kill the held/incoming instruction
- wb_en  in  1  register write enable
- wb_addr  in  5  register write address
- wb_data  in  DATA_W  register write data
- out_valid  out  1  execute-side payload valid
- out_ready  in  1  execute stage accepts payload
- ex_pc, ex_opcode, ex_funct, ex_shamt, ex_isRtype, ex_isItype  out  (as inputs)  registered copies
- ex_rs_data  out  DATA_W  operand A
- ex_rt_data  out  DATA_W  operand B
- ex_imm  out  DATA_W  extended immediate
- ex_dest  out  5  destination register (0 = no write)

Behaviour:
- Reset (reset=0, asynchronous): all 32 registers = 0; out_valid=0; all ex_* outputs = 0.
- Register file:
  - r0 reads 0 always; writes to r0 ignored.
  - Write on rising edge when wb_en=1 and wb_addr!=0.
  - Reads combinational from rs/rt.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
  - Capture on edge when in_valid && in_ready && !flush → out_valid=1 next cycle, latency 1 cycle.
  - If out_valid && out_ready and no capture → out_valid=0.
  - If out_valid && !out_ready → all ex_* held stable (except hold-refresh below).
- Flush: on edge with flush=1, out_valid=0 regardless of in_valid/out_ready; incoming instruction dropped. Flush has priority over capture.
- Dest select: ex_dest = isRtype ? rd : (isItype ? rt : 0).
- Immediate extension:
  - Zero-extend when opcode is 0x0C, 0x0D or 0x0E (andi/ori/xori).
  - Otherwise sign-extend from bit 15.
  - R-type: ex_imm = 0.
- Hold-refresh: while out_valid && !out_ready, a writeback (wb_en, wb_addr!=0) whose address equals the held rs (or rt) updates ex_rs_data (or ex_rt_data) with wb_data on that edge. The stage stores the captured rs/rt addresses for this comparison.
- Same-edge capture + writeback to a source register: behaviour set by the optional feature below.
- Reset deasserted mid-stream: the first capture is allowed on the first edge after deassertion.

Optional Feature:
- Macro: DECODE_OPERAND_BYPASS_EN.
- Defined: on a capture edge, if wb_en && wb_addr!=0 && wb_addr==rs (or rt), the captured operand is wb_data (write-through bypass).
- Undefined: the captured operand is the pre-write register value; software/hazard logic must insert a stall. Hold-refresh is present in both builds.

Decomposition:
- Shared package: opcode constants (OP_RTYPE=0x00, OP_ANDI=0x0C, OP_ORI=0x0D, OP_XORI=0x0E), REG_ADDR_W=5, register-zero constant.
- One sub-module, register_file (32x32, 2 async read ports, 1 sync write port, async active-low clear); the pipeline register, extension and handshake stay in the top.

Test Plan:
- Reset: reset=0 mid-run with out_valid=1 → out_valid=0 and ex_rs_data=0 immediately; after release, reading r5 gives 0.
- Write then read:
  - Write r5=0x0000_1234 and r6=0xFFFF_0001.
  - R-type rs=5, rt=6, rd=7 → next cycle ex_rs_data=0x1234, ex_rt_data=0xFFFF0001, ex_dest=7, ex_imm=0.
- Extension:
  - addi (0x08) imm=0x8000 → ex_imm=0xFFFF8000, ex_dest=rt.
  - ori (0x0D) imm=0x8000 → ex_imm=0x00008000.
  - wb to r0 with 0xDEAD then rs=0 → ex_rs_data=0.
- Backpressure:
  - out_ready=0 for 3 cycles → in_ready=0 and ex_* stable.
  - A wb to the held rs=5 with 0xABCD during the stall → ex_rs_data=0xABCD.
  - With out_ready=1 and in_valid=1 every cycle → one capture per cycle, no bubbles.
- Flush and bypass:
  - flush=1 with in_valid=1 → out_valid=0 next cycle.
  - Capture rs=9 while wb writes r9=0x55 → ex_rs_data=0x55 with DECODE_OPERAND_BYPASS_EN defined, old value without it.
